game_timer_ctrl: RTL and testbench

Game-level controller sitting directly downstream of the countdown timer in the sliding-puzzle design. It consumes the timer's live minute/second value. It drives the timer's load (active-low reset) and enable inputs through an IDLE/RUN/PAUSE/DONE state machine, and detects time-up or puzzle-solved. It also produces registered BCD digits plus a low-time warning/blink for the seven-segment display stage.

---
 rtl/game_timer_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
//
// Game-level controller placed directly after the countdown timer of the
// sliding-puzzle design. It runs the IDLE/RUN/PAUSE/DONE game flow and drives
// the timer's load/enable pins. It detects the end of a game, either by time-up
// at 0:00 or by a solved board. It also registers BCD digits and a low-time
// warning/blink for the seven-segment display stage.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   start         in   pulse: IDLE -> RUN, DONE -> IDLE
//   pause_toggle  in   pulse: RUN <-> PAUSE
//   solved        in   pulse: board solved (honoured in RUN only)
//   minute_in     in   live timer minutes (0..9 expected)
//   second_in     in   live timer seconds (0..59 expected)
//   timer_load_n  out  0 = timer holds/loads its preset
//   timer_enable  out  1 = timer counts down
//   state         out  IDLE=0, RUN=1, PAUSE=2, DONE=3 (raw state register)
//   time_up       out  sticky: game ended on 0:00
//   won           out  sticky: game ended by solved
//   warning       out  low remaining time while game active (registered)
//   blink         out  square wave while warning is high
//   min_digit     out  BCD minutes (registered)
//   sec_tens      out  BCD seconds tens (registered)
//   sec_ones      out  BCD seconds ones (registered)
//
// Control inputs are level-sampled single-cycle pulses, synchronous to clk.
// Nothing here edge-detects them: a pulse held high acts again on every edge.
// -----------------------------------------------------------------------------
module game_timer_ctrl #(
  parameter int WARN_SECONDS = 10,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       solved,
  input  logic [3:0] minute_in,
  input  logic [5:0] second_in,
  output logic       timer_load_n,
  output logic       timer_enable,
  output logic [1:0] state,
  output logic       time_up,
  output logic       won,
  output logic       warning,
  output logic       blink,
  output logic [3:0] min_digit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int             CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLINK_DIV - 1);
  localparam logic [9:0]     WARN_LIM  = 10'(WARN_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t cur_state, nxt_state;
  logic   won_nxt, time_up_nxt;

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_IDLE;
      won       <= 1'b0;
      time_up   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      won       <= won_nxt;
      time_up   <= time_up_nxt;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    won_nxt      = won;
    time_up_nxt  = time_up;
    timer_load_n = 1'b1;
    timer_enable = 1'b0;
    case (cur_state)
      S_IDLE: begin
        timer_load_n = 1'b0;
        if (start) nxt_state = S_RUN;
      end
      S_RUN: begin
        timer_enable = 1'b1;
        // A solved board on the very edge time runs out still counts as a win.
        if (solved) begin
          nxt_state = S_DONE;
          won_nxt   = 1'b1;
        end else if (minute_in == 4'd0 && second_in == 6'd0) begin
          // Live inputs: enable drops on this edge so the timer stays at 0:00.
          nxt_state   = S_DONE;
          time_up_nxt = 1'b1;
        end else if (pause_toggle) begin
          nxt_state = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_toggle) nxt_state = S_RUN;
      end
      S_DONE: begin
        if (start) begin
          nxt_state   = S_IDLE;
          won_nxt     = 1'b0;
          time_up_nxt = 1'b0;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign state = cur_state;

  // ---------------------------------------------------------------------------
  // Display digits and warning
  // ---------------------------------------------------------------------------
  logic [3:0] min_c;
  logic [5:0] sec_c;
  logic [5:0] tens_w, ones_w;
  logic [9:0] total;
  logic       warn_nxt;

  always_comb begin
    min_c  = (minute_in > 4'd9)  ? 4'd9  : minute_in;
    sec_c  = (second_in > 6'd59) ? 6'd59 : second_in;
    tens_w = sec_c / 6'd10;
    ones_w = sec_c % 6'd10;
    // Warning threshold uses the raw (unclamped) inputs.
    total    = ({6'd0, minute_in} * 10'd60) + {4'd0, second_in};
    warn_nxt = ((cur_state == S_RUN) || (cur_state == S_PAUSE)) &&
               (total != 10'd0) && (total <= WARN_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_digit <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      warning   <= 1'b0;
    end else begin
      min_digit <= min_c;
      sec_tens  <= tens_w[3:0];
      sec_ones  <= ones_w[3:0];
      warning   <= warn_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink generator
  // blink is cleared on the same edge that warning falls, and the counter
  // only starts counting once warning is already high, so the first rise of
  // blink lands BLINK_DIV edges after warning rises.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= CNT_RELOAD;
      blink     <= 1'b0;
    end else if (!warn_nxt) begin
      blink_cnt <= CNT_RELOAD;
      blink     <= 1'b0;
    end else if (!warning) begin
      blink_cnt <= CNT_RELOAD;
    end else if (blink_cnt == '0) begin
      blink_cnt <= CNT_RELOAD;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
module tb_game_timer_ctrl;

  localparam int WARN = 10;
  localparam int BDIV = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0, pause_toggle = 1'b0, solved = 1'b0;
  logic [3:0] minute_in = 4'd0;
  logic [5:0] second_in = 6'd0;
  logic       timer_load_n, timer_enable, time_up, won, warning, blink;
  logic [1:0] state;
  logic [3:0] min_digit, sec_tens, sec_ones;

  game_timer_ctrl #(.WARN_SECONDS(WARN), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .reset(reset), .start(start), .pause_toggle(pause_toggle),
    .solved(solved), .minute_in(minute_in), .second_in(second_in),
    .timer_load_n(timer_load_n), .timer_enable(timer_enable), .state(state),
    .time_up(time_up), .won(won), .warning(warning), .blink(blink),
    .min_digit(min_digit), .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: game phase as a plain integer, display values from
  // arithmetic on the sampled inputs, blink from the length of the warning run.
  // ---------------------------------------------------------------------------
  int m_phase = 0;   // 0 idle, 1 run, 2 pause, 3 done
  int m_won = 0, m_tu = 0, m_warn = 0, m_run = 0;
  int m_min = 0, m_tens = 0, m_ones = 0;

  function automatic int exp_blink();
    if (m_run == 0) return 0;
    return ((m_run - 1) / BDIV) % 2;
  endfunction

  task automatic model_edge(input int r, st, pt, sv, mi, si);
    int tot, cm, cs, active;
    tot    = mi * 60 + si;
    cm     = (mi > 9) ? 9 : mi;
    cs     = (si > 59) ? 59 : si;
    active = (m_phase == 1 || m_phase == 2);
    if (r != 0) begin
      m_phase = 0; m_won = 0; m_tu = 0; m_warn = 0;
      m_min = 0; m_tens = 0; m_ones = 0;
    end else begin
      m_warn = (active != 0 && tot != 0 && tot <= WARN) ? 1 : 0;
      m_min  = cm;
      m_tens = cs / 10;
      m_ones = cs % 10;
      if (m_phase == 0) begin
        if (st != 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (sv != 0) begin m_phase = 3; m_won = 1; end
        else if (tot == 0) begin m_phase = 3; m_tu = 1; end
        else if (pt != 0) m_phase = 2;
      end else if (m_phase == 2) begin
        if (pt != 0) m_phase = 1;
      end else begin
        if (st != 0) begin m_phase = 0; m_won = 0; m_tu = 0; end
      end
    end
    m_run = (m_warn != 0) ? m_run + 1 : 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard checks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("state",        int'(state),        m_phase);
    check("timer_load_n", int'(timer_load_n), (m_phase != 0) ? 1 : 0);
    check("timer_enable", int'(timer_enable), (m_phase == 1) ? 1 : 0);
    check("won",          int'(won),          m_won);
    check("time_up",      int'(time_up),      m_tu);
    check("warning",      int'(warning),      m_warn);
    check("blink",        int'(blink),        exp_blink());
    check("min_digit",    int'(min_digit),    m_min);
    check("sec_tens",     int'(sec_tens),     m_tens);
    check("sec_ones",     int'(sec_ones),     m_ones);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, clock one edge, update model, check 1 time unit later
  // ---------------------------------------------------------------------------
  task automatic step(input int r, st, pt, sv, mi, si);
    reset        = r[0];
    start        = st[0];
    pause_toggle = pt[0];
    solved       = sv[0];
    minute_in    = mi[3:0];
    second_in    = si[5:0];
    @(posedge clk);
    model_edge(r, st, pt, sv, mi, si);
    #1;
    check_all();
  endtask

  task automatic hold(input int n, mi, si);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, mi, si);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // reset, then idle with 3:45 on the inputs
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 3, 45);        // pause/solved ignored in IDLE
    check("idle_digit_min", int'(min_digit), 3);
    check("idle_digit_ones", int'(sec_ones), 5);

    // start, count down into the warning window, watch blink
    step(0, 1, 0, 0, 0, 12);
    check("run_enable", int'(timer_enable), 1);
    hold(2, 0, 12);
    hold(3, 0, 10);
    hold(12, 0, 9);
    // 0:00 in RUN -> DONE with time_up
    step(0, 0, 0, 0, 0, 0);
    check("timeup_state", int'(state), 3);
    check("timeup_flag", int'(time_up), 1);
    hold(2, 0, 0);
    step(0, 1, 0, 0, 0, 0);         // back to IDLE
    check("done_to_idle_load", int'(timer_load_n), 0);

    // start+pause together in IDLE: start wins
    step(0, 1, 1, 0, 1, 30);
    step(0, 0, 1, 0, 1, 30);        // RUN -> PAUSE
    step(0, 0, 0, 1, 1, 30);        // solved ignored in PAUSE
    step(0, 1, 0, 0, 1, 30);        // start ignored in PAUSE
    step(0, 0, 1, 0, 1, 29);        // PAUSE -> RUN
    check("resume_state", int'(state), 1);

    // paused inside the warning window keeps warning/blink going
    hold(2, 0, 8);
    step(0, 0, 1, 0, 0, 7);
    hold(6, 0, 7);
    step(0, 0, 1, 0, 0, 7);

    // solved and 0:00 on the same edge: won wins
    step(0, 0, 0, 1, 0, 0);
    check("both_won", int'(won), 1);
    check("both_timeup", int'(time_up), 0);
    step(0, 1, 0, 0, 5, 0);

    // 0:00 preset: first RUN edge ends the game
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // out-of-range inputs clamp; reset in RUN
    step(0, 1, 0, 0, 12, 63);
    step(0, 0, 0, 0, 12, 63);
    check("clamp_min", int'(min_digit), 9);
    check("clamp_tens", int'(sec_tens), 5);
    check("clamp_ones", int'(sec_ones), 9);
    hold(2, 0, 5);
    step(1, 0, 0, 0, 0, 5);
    check("reset_state", int'(state), 0);
    step(0, 0, 0, 0, 0, 5);

    // randomized play
    for (int i = 0; i < 600; i++) begin
      int r, st, pt, sv, mi, si;
      r  = ($urandom_range(0, 99) < 2)  ? 1 : 0;
      st = ($urandom_range(0, 99) < 8)  ? 1 : 0;
      pt = ($urandom_range(0, 99) < 6)  ? 1 : 0;
      sv = ($urandom_range(0, 99) < 3)  ? 1 : 0;
      if ($urandom_range(0, 3) != 0) begin
        mi = ($urandom_range(0, 5) == 0) ? 1 : 0;
        si = $urandom_range(0, 14);
      end else begin
        mi = $urandom_range(0, 15);
        si = $urandom_range(0, 63);
      end
      step(r, st, pt, sv, mi, si);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
